// File: rtl/stream_arb_mux_pkg.sv
// Shared definitions for the stream_arb_mux block.
//   clog2 / ch_width : channel-index width derivation (minimum 1 bit)
//   MODE_FIXED/MODE_RR : arbitration mode encodings for RR_MODE
package stream_arb_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of a channel index; never zero so out_chan always exists.
  function automatic int ch_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/stream_arb_mux_rr_arbiter.sv
// rr_arbiter: purely combinational grant selection for stream_arb_mux.
//   req       in  CHANNELS  per-channel request (in_valid)
//   ptr       in  CH_W      round-robin search start (ignored in fixed mode)
//   lock      in  1         a packet is in flight; only lock_chan may be granted
//   lock_chan in  CH_W      channel owning the packet in flight
//   gnt       out CHANNELS  one-hot grant, zero when nothing is grantable
//   gnt_idx   out CH_W      binary index of the granted (or locked) channel
module rr_arbiter
  import stream_arb_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int RR_MODE  = MODE_RR,
  localparam int CH_W    = ch_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_W-1:0]     ptr,
  input  logic                lock,
  input  logic [CH_W-1:0]     lock_chan,
  output logic [CHANNELS-1:0] gnt,
  output logic [CH_W-1:0]     gnt_idx
);

  logic            found;
  logic [CH_W:0]   cand_ext;
  logic [CH_W-1:0] cand;

  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    cand_ext = '0;
    cand     = '0;
    if (lock) begin
      // Mid-packet: the owner keeps the grant even if it is not requesting,
      // so no other channel can interleave beats into the packet.
      gnt_idx = lock_chan;
      found   = req[lock_chan];
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (RR_MODE != MODE_FIXED) begin
          // ptr + i wrapped modulo CHANNELS (works for non power-of-two counts)
          cand_ext = {1'b0, ptr} + (CH_W+1)'(i);
          if (cand_ext >= (CH_W+1)'(CHANNELS)) begin
            cand_ext = cand_ext - (CH_W+1)'(CHANNELS);
          end
        end else begin
          cand_ext = (CH_W+1)'(i);
        end
        cand = cand_ext[CH_W-1:0];
        if (!found && req[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    gnt = found ? (CHANNELS'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/stream_arb_mux.sv
// stream_arb_mux: CHANNELS-to-1 registered stream multiplexer with
// round-robin or fixed-priority arbitration and packet locking on in_last.
//   clk/reset  synchronous active-high reset
//   in_data    CHANNELS*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid       in_last  per-channel end-of-packet
//   in_ready   per-channel accept (combinational, at most one bit high)
//   out_data/out_last/out_chan/out_valid  registered output beat
//   out_ready  downstream accept
//
// Handshake: a beat moves on any edge where valid and ready are both high.
// The output register is reloadable whenever it is empty or being consumed
// (load = !out_valid || out_ready), so consumption and refill happen on the
// same edge and a continuous stream runs at one beat per cycle.
module stream_arb_mux
  import stream_arb_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int RR_MODE  = MODE_RR,
  localparam int CH_W    = ch_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [CH_W-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic                out_last_q,  out_last_d;
  logic [CH_W-1:0]     out_chan_q,  out_chan_d;
  logic                out_valid_q, out_valid_d;
  logic                locked_q,    locked_d;
  logic [CH_W-1:0]     lock_chan_q, lock_chan_d;
  logic [CH_W-1:0]     rr_ptr_q,    rr_ptr_d;

  logic                load;
  logic                xfer;
  logic [CHANNELS-1:0] gnt;
  logic [CH_W-1:0]     gnt_idx;
  logic [WIDTH-1:0]    sel_data;
  logic                sel_last;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .RR_MODE  (RR_MODE)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .lock      (locked_q),
    .lock_chan (lock_chan_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx)
  );

  assign load     = !out_valid_q || out_ready;
  assign in_ready = (load && !reset) ? gnt : '0;
  assign xfer     = |in_ready;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (gnt_idx == CH_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_last = in_last[k];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    locked_d    = locked_q;
    lock_chan_d = lock_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      if (xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = sel_data;
        out_last_d  = sel_last;
        out_chan_d  = gnt_idx;
        if (sel_last) begin
          // Packet done: release the lock and move priority past this channel.
          locked_d = 1'b0;
          rr_ptr_d = (gnt_idx == CH_W'(CHANNELS-1)) ? '0 : gnt_idx + CH_W'(1);
        end else begin
          locked_d    = 1'b1;
          lock_chan_d = gnt_idx;
        end
      end else begin
        // Register drained with nothing to refill; payload fields hold.
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      lock_chan_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      locked_q    <= locked_d;
      lock_chan_q <= lock_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: a round-robin instance and a fixed-priority
// instance share one set of inputs; both are compared every cycle against a
// rule-level model, with a beat scoreboard and directed literal checks.
module tb_stream_arb_mux;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int CW = 2;

  logic            clk;
  logic            reset;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_last;
  logic            out_ready;

  logic [CH-1:0]   r_in_ready, f_in_ready;
  logic [W-1:0]    r_out_data, f_out_data;
  logic            r_out_last, f_out_last;
  logic [CW-1:0]   r_out_chan, f_out_chan;
  logic            r_out_valid, f_out_valid;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  stream_arb_mux #(.WIDTH(W), .CHANNELS(CH), .RR_MODE(1)) u_rr (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(r_in_ready), .out_data(r_out_data),
    .out_last(r_out_last), .out_chan(r_out_chan), .out_valid(r_out_valid),
    .out_ready(out_ready)
  );

  stream_arb_mux #(.WIDTH(W), .CHANNELS(CH), .RR_MODE(0)) u_fp (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(f_in_ready), .out_data(f_out_data),
    .out_last(f_out_last), .out_chan(f_out_chan), .out_valid(f_out_valid),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance (0 = round-robin, 1 = fixed priority): output register
  // contents, lock owner and round-robin start channel.
  int m_valid[2], m_data[2], m_last[2], m_chan[2];
  int m_locked[2], m_lock_chan[2], m_ptr[2];

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 0; m_data[u] = 0; m_last[u] = 0; m_chan[u] = 0;
      m_locked[u] = 0; m_lock_chan[u] = 0; m_ptr[u] = 0;
    end
  end

  // Round-robin: the valid channel at the smallest forward distance from ptr.
  // Fixed: the smallest valid index. Locked: only the owner, if valid.
  function automatic int model_grant(input logic [CH-1:0] v, input int locked,
                                     input int lchan, input int ptr, input int rr);
    int best, bestd, d;
    if (locked != 0) return v[lchan] ? lchan : -1;
    best  = -1;
    bestd = CH;
    for (int k = 0; k < CH; k++) begin
      if (v[k]) begin
        d = (rr != 0) ? ((k - ptr + CH) % CH) : k;
        if (d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
    end
    return best;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W+CW:0] exp_q0[$];
  logic [W+CW:0] exp_q1[$];

  task automatic sb_push(input int u, input logic [W+CW:0] beat);
    if (u == 0) exp_q0.push_back(beat);
    else        exp_q1.push_back(beat);
  endtask

  task automatic sb_clear(input int u);
    if (u == 0) exp_q0.delete();
    else        exp_q1.delete();
  endtask

  task automatic sb_pop(input int u, input string tag, input logic [W+CW:0] act);
    logic [W+CW:0] e;
    if ((u == 0 && exp_q0.size() == 0) || (u == 1 && exp_q1.size() == 0)) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_sb: got beat %0h expected none (queue empty)", tag, act);
    end else begin
      if (u == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      chk({tag, "_sb_beat"}, 32'(act), 32'(e));
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [CH-1:0] d_rdy, e_rdy;
  logic          d_ov, d_ol;
  logic [W-1:0]  d_od;
  logic [CW-1:0] d_oc;
  int            g, load;
  string         tag;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (u == 0) begin
        tag = "rr";
        d_rdy = r_in_ready; d_ov = r_out_valid; d_ol = r_out_last;
        d_od = r_out_data; d_oc = r_out_chan;
      end else begin
        tag = "fp";
        d_rdy = f_in_ready; d_ov = f_out_valid; d_ol = f_out_last;
        d_od = f_out_data; d_oc = f_out_chan;
      end
      load  = (m_valid[u] == 0 || out_ready) ? 1 : 0;
      g     = model_grant(in_valid, m_locked[u], m_lock_chan[u], m_ptr[u], (u == 0) ? 1 : 0);
      e_rdy = (!reset && load != 0 && g >= 0) ? CH'(1 << g) : '0;
      chk({tag, "_in_ready"},  32'(d_rdy), 32'(e_rdy));
      chk({tag, "_out_valid"}, 32'(d_ov), 32'(m_valid[u]));
      chk({tag, "_out_data"},  32'(d_od), 32'(m_data[u]));
      chk({tag, "_out_last"},  32'(d_ol), 32'(m_last[u]));
      chk({tag, "_out_chan"},  32'(d_oc), 32'(m_chan[u]));

      if (reset) begin
        sb_clear(u);
        m_valid[u] = 0; m_data[u] = 0; m_last[u] = 0; m_chan[u] = 0;
        m_locked[u] = 0; m_lock_chan[u] = 0; m_ptr[u] = 0;
      end else begin
        if (d_ov && out_ready) sb_pop(u, tag, {d_oc, d_ol, d_od});
        if (load != 0) begin
          if (g >= 0) begin
            m_valid[u] = 1;
            m_data[u]  = int'(in_data[g*W +: W]);
            m_last[u]  = int'(in_last[g]);
            m_chan[u]  = g;
            sb_push(u, {CW'(g), in_last[g], in_data[g*W +: W]});
            if (in_last[g]) begin
              m_locked[u] = 0;
              m_ptr[u]    = (g + 1) % CH;
            end else begin
              m_locked[u]    = 1;
              m_lock_chan[u] = g;
            end
          end else begin
            m_valid[u] = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] d, input logic l);
    in_data[ch*W +: W] = d;
    in_last[ch]        = l;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
    out_ready = 1'b1;

    // 1. reset held with every channel valid
    repeat (2) begin
      @(negedge clk);
      chk("t1_rr_in_ready_rst", 32'(r_in_ready), 32'h0);
      chk("t1_fp_in_ready_rst", 32'(f_in_ready), 32'h0);
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 4'b0000;
    chk("t1_out_valid", 32'(r_out_valid), 32'h0);
    chk("t1_out_data",  32'(r_out_data),  32'h0);
    chk("t1_out_chan",  32'(r_out_chan),  32'h0);

    // 2. round-robin single beats, all valid
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2_out_valid", 32'(r_out_valid), 32'h1);
      chk("t2_out_chan",  32'(r_out_chan),  32'(i % 4));
      chk("t2_out_data",  32'(r_out_data),  32'(8'h10 + 8'h11 * (i % 4)));
    end

    // 3. ch1 three-beat packet while ch0 and ch2 stay valid
    in_valid = 4'b0111;
    set_ch(1, 8'hA0, 1'b0);
    cyc();
    chk("t3_beat0_chan", 32'(r_out_chan), 32'h1);
    chk("t3_beat0_data", 32'(r_out_data), 32'hA0);
    chk("t3_beat0_last", 32'(r_out_last), 32'h0);
    set_ch(1, 8'hA1, 1'b0);
    cyc();
    chk("t3_beat1_chan", 32'(r_out_chan), 32'h1);
    chk("t3_beat1_data", 32'(r_out_data), 32'hA1);
    set_ch(1, 8'hA2, 1'b1);
    cyc();
    chk("t3_beat2_chan", 32'(r_out_chan), 32'h1);
    chk("t3_beat2_data", 32'(r_out_data), 32'hA2);
    chk("t3_beat2_last", 32'(r_out_last), 32'h1);
    in_valid = 4'b0101;
    cyc();
    chk("t3_next_chan", 32'(r_out_chan), 32'h2);
    chk("t3_next_data", 32'(r_out_data), 32'h32);
    cyc();
    chk("t3_then_chan", 32'(r_out_chan), 32'h0);
    chk("t3_then_data", 32'(r_out_data), 32'h10);

    // 4. backpressure for three cycles
    out_ready = 1'b0;
    #1;
    chk("t4_in_ready_hold", 32'(r_in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_hold_valid", 32'(r_out_valid), 32'h1);
      chk("t4_hold_data",  32'(r_out_data),  32'h10);
      chk("t4_hold_chan",  32'(r_out_chan),  32'h0);
      chk("t4_in_ready",   32'(r_in_ready),  32'h0);
    end
    out_ready = 1'b1;
    cyc();
    chk("t4_resume_chan", 32'(r_out_chan), 32'h2);
    chk("t4_resume_data", 32'(r_out_data), 32'h32);
    cyc();
    chk("t4_resume2_chan", 32'(r_out_chan), 32'h0);

    // 5. fixed priority, ch0 and ch3 continuously valid
    in_valid = 4'b1001;
    in_last  = 4'b1111;
    cyc();
    for (int i = 0; i < 6; i++) begin
      chk("t5_fp_valid",    32'(f_out_valid), 32'h1);
      chk("t5_fp_chan",     32'(f_out_chan),  32'h0);
      chk("t5_fp_in_ready", 32'(f_in_ready),  32'h1);
      cyc();
    end

    // 6. reset while ch2 holds a lock
    in_valid = 4'b0100;
    set_ch(2, 8'hB0, 1'b0);
    cyc();
    chk("t6_lock_chan", 32'(r_out_chan), 32'h2);
    chk("t6_lock_data", 32'(r_out_data), 32'hB0);
    reset = 1'b1;
    #1;
    chk("t6_in_ready_rst", 32'(r_in_ready), 32'h0);
    cyc();
    chk("t6_rst_valid", 32'(r_out_valid), 32'h0);
    chk("t6_rst_data",  32'(r_out_data),  32'h0);
    reset    = 1'b0;
    in_valid = 4'b0101;
    set_ch(2, 8'hB1, 1'b1);
    cyc();
    chk("t6_first_chan", 32'(r_out_chan), 32'h0);
    chk("t6_first_data", 32'(r_out_data), 32'h10);

    // random traffic, including mid-packet valid drops and rare resets
    for (int n = 0; n < 3000; n++) begin
      in_valid  = CH'($urandom_range(0, 15));
      for (int k = 0; k < CH; k++) begin
        set_ch(k, W'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 249) == 0);
      cyc();
    end
    reset = 1'b0;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
